cfg_frame_loader: RTL and testbench
===================================

Name: cfg_frame_loader

Overview:
Byte-stream framer between the UART receiver and the parameter RAM of the optical clock pulse generator. It collects bytes from the receiver into framed commands and buffers each payload until the checksum is verified. It then either commits the payload to RAM as consecutive single-byte writes, or issues the PC start pulse that arms the pulse/delay chain. Corrupt, malformed, or stalled frames never reach RAM.

Parameters:
MAX_LEN, 32, payload buffer depth in bytes (1..255)
TIMEOUT_CYC, 500000, maximum clk cycles allowed between bytes inside a frame (10 ms at 50 MHz)
SYNC_BYTE, 8'hA5, frame start marker

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  reset, asynchronous, active-high
rx_data  in  8  byte from UART receiver, bit order already corrected
rx_valid  in  1  one-cycle strobe; rx_data is valid in the same cycle
wr  out  1  RAM write strobe, one cycle per byte
wr_addr  out  8  RAM byte address
wr_data  out  8  RAM byte data
pc_start  out  1  one-cycle start pulse to the start controller
frame_ok  out  1  one-cycle pulse when a frame is completed successfully
err  out  1  one-cycle pulse when a frame is rejected
err_code  out  3  cause of the last rejection, held until the next frame_ok or err
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, any state): state=IDLE. wr, pc_start, frame_ok, err, busy=0. wr_addr, wr_data=0. err_code=0. Byte index and timeout counter=0. Buffer RAM contents are not reset.
- Frame format: SYNC, CMD, LEN, ADDR, LEN payload bytes, CHK.
  - CHK = XOR of CMD, LEN, ADDR and all payload bytes.
  - CMD 8'h01 = write params; requires 1<=LEN<=MAX_LEN.
  - CMD 8'h02 = start; requires LEN=0.
- States: IDLE, CMD, LEN, ADDR, PAYLOAD, CHK, COMMIT.
- Transitions (each occurs on an rx_valid cycle):
  - IDLE: rx_data==SYNC_BYTE → CMD. Any other byte is discarded silently (sync hunt).
  - CMD: latch the byte. Unknown CMD → IDLE with err, code 2.
  - LEN: latch the byte. A CMD/LEN mismatch per the rules above → IDLE with err, code 2.
  - ADDR: latch the byte. For CMD 01, ADDR+LEN>256 → IDLE with err, code 3. Otherwise LEN=0 → CHK, else → PAYLOAD.
  - PAYLOAD: write the byte to buffer[idx], idx++. After byte LEN-1 → CHK.
  - CHK: compare with the running XOR.
    - Mismatch → IDLE with err, code 1.
    - Match, CMD 02 → IDLE; pc_start and frame_ok pulse in the next cycle.
    - Match, CMD 01 → COMMIT.
  - COMMIT: one write per cycle for i=0..LEN-1, wr=1, wr_addr=ADDR+i, wr_data=buffer[i].
    - The first wr is asserted on the cycle after the CHK byte's rx_valid cycle.
    - Writes are back to back; there are no gaps.
    - frame_ok pulses in the cycle after the last wr, together with the return to IDLE.
- Outputs are registered. wr_addr and wr_data hold their last values when wr=0.
- Timeout:
  - The counter clears on every accepted byte and counts every cycle in CMD, LEN, ADDR, PAYLOAD and CHK.
  - When it reaches TIMEOUT_CYC: → IDLE with err, code 4. The partial buffer is discarded and nothing is written.
  - The counter is inactive in IDLE and COMMIT.
- Overrun: an rx_valid during COMMIT drops that byte, err pulses with code 5, and the commit still completes.
  - If the overrun coincides with the final wr cycle, the err pulse occurs in the cycle after that byte's rx_valid cycle (the final wr cycle), i.e. the same cycle as frame_ok. Both pulse together, and err_code=5 wins.
- A SYNC byte arriving mid-frame is treated as data; there is no resynchronisation until the frame ends or is rejected.
- Each err pulse is followed by a return to IDLE, except overrun. err and err_code update in the same cycle.
- frame_ok clears err_code to 0.
- Running XOR and idx clear on entry to CMD.

Test Plan:
- Write frame: bytes A5 01 03 10 11 22 33 12 → three consecutive wr cycles: (10,11), (11,22), (12,33). frame_ok is 1 in the cycle after the last wr; err stays 0.
- Start frame: bytes A5 02 00 00 02 → pc_start=1 and frame_ok=1 for one cycle after the CHK byte; no wr.
- Bad checksum: bytes A5 01 03 10 11 22 33 13 → no wr; err=1 with err_code=1. A following valid frame then writes normally and clears err_code.
- Format and range errors:
  - CMD 07 → err_code 2.
  - A5 01 00 → err_code 2.
  - A5 01 21 (with MAX_LEN=32) → err_code 2.
  - A5 01 04 FE → err_code 3.
  - In every case, garbage bytes before the next SYNC are ignored.
- Timeout and reset, with TIMEOUT_CYC=50:
  - A5 01 02 10 11, then silence for 50 cycles → err_code 4, no wr, busy=0.
  - Asserting rst mid-COMMIT clears all outputs immediately (asynchronously) and leaves the block in IDLE.
- Overrun: inject rx_valid during the 3-write commit → err_code 5, all 3 writes still occur, frame_ok is asserted.

Source files
------------

// File: rtl/cfg_frame_loader.sv
// UART byte-stream framer: SYNC,CMD,LEN,ADDR,payload,CHK -> buffered RAM byte writes or a PC start pulse.
// First wr / pc_start one cycle after the CHK byte; no backpressure, bytes arriving during commit are dropped (overrun).
module cfg_frame_loader #(
  parameter int          MAX_LEN     = 32,
  parameter int          TIMEOUT_CYC = 500000,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       wr,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       pc_start,
  output logic       frame_ok,
  output logic       err,
  output logic [2:0] err_code,
  output logic       busy
);

  localparam int             IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int             TW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]     MAX_LEN8  = 8'(MAX_LEN);
  localparam logic [7:0]     CMD_WR    = 8'h01;
  localparam logic [7:0]     CMD_START = 8'h02;
  localparam logic [2:0]     E_CHK     = 3'd1;
  localparam logic [2:0]     E_FMT     = 3'd2;
  localparam logic [2:0]     E_RANGE   = 3'd3;
  localparam logic [2:0]     E_TMO     = 3'd4;
  localparam logic [2:0]     E_OVR     = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_LEN, S_ADDR, S_PAYLOAD, S_CHK, S_COMMIT
  } state_t;

  state_t         state_q;
  logic [7:0]     cmd_q;
  logic [7:0]     len_q;
  logic [7:0]     addr_q;
  logic [7:0]     xor_q;
  logic [7:0]     idx_q;
  logic [TW-1:0]  tmo_q;
  logic [7:0]     buf_q [MAX_LEN];

  logic           wr_q;
  logic [7:0]     wr_addr_q;
  logic [7:0]     wr_data_q;
  logic           pc_start_q;
  logic           frame_ok_q;
  logic           err_q;
  logic [2:0]     err_code_q;

  logic           in_frame_d;
  logic           tmo_hit_d;
  logic           len_ok_d;
  logic [8:0]     addr_end_d;
  logic           range_bad_d;
  logic           last_pl_d;
  logic           commit_done_d;
  logic           buf_we_d;
  logic [7:0]     buf_rd_d;

  assign in_frame_d    = (state_q != S_IDLE) && (state_q != S_COMMIT);
  assign tmo_hit_d     = (tmo_q == TMO_LAST);
  assign len_ok_d      = (cmd_q == CMD_WR) ? ((rx_data != 8'd0) && (rx_data <= MAX_LEN8))
                                           : (rx_data == 8'd0);
  assign addr_end_d    = {1'b0, rx_data} + {1'b0, len_q};
  assign range_bad_d   = (cmd_q == CMD_WR) && (addr_end_d > 9'd256);
  assign last_pl_d     = (idx_q == (len_q - 8'd1));
  assign commit_done_d = (idx_q == len_q);
  assign buf_we_d      = (state_q == S_PAYLOAD) && rx_valid;
  assign buf_rd_d      = buf_q[idx_q[IW-1:0]];

  // Payload buffer is plain storage; it is never reset and only read during commit.
  always_ff @(posedge clk) begin
    if (buf_we_d) begin
      buf_q[idx_q[IW-1:0]] <= rx_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      xor_q      <= '0;
      idx_q      <= '0;
      tmo_q      <= '0;
      wr_q       <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      pc_start_q <= 1'b0;
      frame_ok_q <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= '0;
    end else begin
      wr_q       <= 1'b0;
      pc_start_q <= 1'b0;
      frame_ok_q <= 1'b0;
      err_q      <= 1'b0;

      if (!in_frame_d || rx_valid) begin
        tmo_q <= '0;
      end else begin
        tmo_q <= tmo_q + TW'(1);
      end

      case (state_q)
        S_IDLE: begin
          if (rx_valid && (rx_data == SYNC_BYTE)) begin
            state_q <= S_CMD;
            xor_q   <= '0;
            idx_q   <= '0;
          end
        end
        S_CMD: begin
          if (rx_valid) begin
            cmd_q <= rx_data;
            xor_q <= xor_q ^ rx_data;
            if ((rx_data == CMD_WR) || (rx_data == CMD_START)) begin
              state_q <= S_LEN;
            end else begin
              state_q    <= S_IDLE;
              err_q      <= 1'b1;
              err_code_q <= E_FMT;
            end
          end
        end
        S_LEN: begin
          if (rx_valid) begin
            len_q <= rx_data;
            xor_q <= xor_q ^ rx_data;
            if (len_ok_d) begin
              state_q <= S_ADDR;
            end else begin
              state_q    <= S_IDLE;
              err_q      <= 1'b1;
              err_code_q <= E_FMT;
            end
          end
        end
        S_ADDR: begin
          if (rx_valid) begin
            addr_q <= rx_data;
            xor_q  <= xor_q ^ rx_data;
            if (range_bad_d) begin
              state_q    <= S_IDLE;
              err_q      <= 1'b1;
              err_code_q <= E_RANGE;
            end else if (len_q == 8'd0) begin
              state_q <= S_CHK;
            end else begin
              state_q <= S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (rx_valid) begin
            xor_q <= xor_q ^ rx_data;
            idx_q <= idx_q + 8'd1;
            if (last_pl_d) begin
              state_q <= S_CHK;
            end
          end
        end
        S_CHK: begin
          if (rx_valid) begin
            if (rx_data != xor_q) begin
              state_q    <= S_IDLE;
              err_q      <= 1'b1;
              err_code_q <= E_CHK;
            end else if (cmd_q == CMD_START) begin
              state_q    <= S_IDLE;
              pc_start_q <= 1'b1;
              frame_ok_q <= 1'b1;
              err_code_q <= '0;
            end else begin
              // First write issues on the CHK edge so commit starts with no bubble.
              state_q   <= S_COMMIT;
              wr_q      <= 1'b1;
              wr_addr_q <= addr_q;
              wr_data_q <= buf_q[0];
              idx_q     <= 8'd1;
            end
          end
        end
        S_COMMIT: begin
          if (rx_valid) begin
            err_q      <= 1'b1;
            err_code_q <= E_OVR;
          end
          if (commit_done_d) begin
            state_q    <= S_IDLE;
            frame_ok_q <= 1'b1;
            if (!rx_valid) begin
              err_code_q <= '0;
            end
          end else begin
            wr_q      <= 1'b1;
            wr_addr_q <= addr_q + idx_q;
            wr_data_q <= buf_rd_d;
            idx_q     <= idx_q + 8'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // An inter-byte gap that runs out abandons the frame; a byte on the same cycle wins.
      if (in_frame_d && !rx_valid && tmo_hit_d) begin
        state_q    <= S_IDLE;
        tmo_q      <= '0;
        err_q      <= 1'b1;
        err_code_q <= E_TMO;
      end
    end
  end

  assign wr       = wr_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign pc_start = pc_start_q;
  assign frame_ok = frame_ok_q;
  assign err      = err_q;
  assign err_code = err_code_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_cfg_frame_loader.sv
// Directed frame-level bench for cfg_frame_loader (MAX_LEN=32, TIMEOUT_CYC=50).
module tb_cfg_frame_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       wr;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       pc_start;
  logic       frame_ok;
  logic       err;
  logic [2:0] err_code;
  logic       busy;

  cfg_frame_loader #(.MAX_LEN(32), .TIMEOUT_CYC(50), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .wr(wr), .wr_addr(wr_addr), .wr_data(wr_data), .pc_start(pc_start),
    .frame_ok(frame_ok), .err(err), .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  n;
    logic [95:0] b;
    logic [7:0]  nwr;
    logic [47:0] w;
    logic [7:0]  ok;
    logic [7:0]  pcs;
    logic [7:0]  errs;
    logic [2:0]  code;
    logic [2:0]  code_after;
  } vec_t;

  localparam int NV = 11;
  vec_t vt [NV];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [15:0] wq [$];
  int first_wr, last_wr, ok_cnt, ok_cyc, pcs_cnt, pcs_cyc, err_cnt, both;
  logic [2:0] err_code_at;

  function automatic vec_t mk(input int n, input logic [95:0] b, input int nwr,
                              input logic [47:0] w, input int ok, input int pcs,
                              input int errs, input logic [2:0] code,
                              input logic [2:0] code_after);
    vec_t v;
    v.n = 8'(n); v.b = b; v.nwr = 8'(nwr); v.w = w; v.ok = 8'(ok);
    v.pcs = 8'(pcs); v.errs = 8'(errs); v.code = code; v.code_after = code_after;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clr_mon();
    wq.delete();
    first_wr = -1; last_wr = -1; ok_cnt = 0; ok_cyc = -1;
    pcs_cnt = 0; pcs_cyc = -1; err_cnt = 0; both = 0; err_code_at = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (wr) begin
      wq.push_back({wr_addr, wr_data});
      if (wq.size() == 1) first_wr = cyc;
      last_wr = cyc;
    end
    if (frame_ok) begin ok_cnt++; ok_cyc = cyc; end
    if (pc_start) begin pcs_cnt++; pcs_cyc = cyc; end
    if (err) begin
      err_cnt++;
      err_code_at = err_code;
      if (frame_ok) both = 1;
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    rx_data = d;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input vec_t v);
    logic [95:0] bb;
    bb = v.b;
    for (int k = 0; k < int'(v.n); k++) send_byte(bb[(int'(v.n) - 1 - k) * 8 +: 8]);
  endtask

  initial begin
    vec_t v;
    logic [47:0] ww;
    int lb;
    int c;

    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    vt[0]  = mk(8, 96'hA5_01_03_10_11_22_33_12, 3, 48'h1011_1122_1233, 1, 0, 0, 3'd0, 3'd0);
    vt[1]  = mk(5, 96'hA5_02_00_00_02,          0, 48'h0,            1, 1, 0, 3'd0, 3'd0);
    vt[2]  = mk(8, 96'hA5_01_03_10_11_22_33_13, 0, 48'h0,            0, 0, 1, 3'd1, 3'd1);
    vt[3]  = mk(6, 96'hA5_01_01_FF_5A_A5,       1, 48'hFF5A,         1, 0, 0, 3'd0, 3'd0);
    vt[4]  = mk(4, 96'h33_44_A5_07,             0, 48'h0,            0, 0, 1, 3'd2, 3'd2);
    vt[5]  = mk(3, 96'hA5_01_00,                0, 48'h0,            0, 0, 1, 3'd2, 3'd2);
    vt[6]  = mk(3, 96'hA5_01_21,                0, 48'h0,            0, 0, 1, 3'd2, 3'd2);
    vt[7]  = mk(4, 96'hA5_01_04_FE,             0, 48'h0,            0, 0, 1, 3'd3, 3'd3);
    vt[8]  = mk(7, 96'h00_5A_A5_02_00_07_05,    0, 48'h0,            1, 1, 0, 3'd0, 3'd0);
    vt[9]  = mk(7, 96'hA5_01_02_20_A5_A5_23,    2, 48'h20A5_21A5,    1, 0, 0, 3'd0, 3'd0);
    vt[10] = mk(5, 96'h77_A5_02_01_00,          0, 48'h0,            0, 0, 1, 3'd2, 3'd2);

    #12;
    chk("rst_wr", wr, 0);           chk("rst_pc_start", pc_start, 0);
    chk("rst_frame_ok", frame_ok, 0); chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);       chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0); chk("rst_err_code", err_code, 0);
    @(negedge clk); rst = 1'b0;
    tick(); tick();

    for (int i = 0; i < NV; i++) begin
      v = vt[i];
      ww = v.w;
      clr_mon();
      send_frame(v);
      lb = cyc;
      repeat (8) tick();
      chk($sformatf("v%0d_nwr", i), wq.size(), v.nwr);
      for (int j = 0; j < int'(v.nwr) && j < wq.size(); j++)
        chk($sformatf("v%0d_wr%0d", i, j), wq[j], ww[(int'(v.nwr) - 1 - j) * 16 +: 16]);
      if (v.nwr > 0) begin
        chk($sformatf("v%0d_first_wr_cyc", i), first_wr, lb);
        chk($sformatf("v%0d_back_to_back", i), last_wr - first_wr, int'(v.nwr) - 1);
        chk($sformatf("v%0d_ok_after_last_wr", i), ok_cyc, last_wr + 1);
        chk($sformatf("v%0d_hold", i), {wr_addr, wr_data}, ww[15:0]);
      end
      if (v.pcs > 0) chk($sformatf("v%0d_pcs_cyc", i), pcs_cyc, lb);
      chk($sformatf("v%0d_frame_ok", i), ok_cnt, v.ok);
      chk($sformatf("v%0d_pc_start", i), pcs_cnt, v.pcs);
      chk($sformatf("v%0d_err", i), err_cnt, v.errs);
      if (v.errs > 0) chk($sformatf("v%0d_err_code", i), err_code_at, v.code);
      chk($sformatf("v%0d_code_after", i), err_code, v.code_after);
      chk($sformatf("v%0d_busy", i), busy, 0);
    end

    // Timeout after a partial payload.
    clr_mon();
    send_frame(mk(5, 96'hA5_01_02_10_11, 0, 48'h0, 0, 0, 0, 3'd0, 3'd0));
    lb = cyc;
    c = 0;
    while (err_cnt == 0 && c < 100) begin tick(); c++; end
    chk("tmo_seen", err_cnt, 1);
    chk("tmo_window", (c >= 49 && c <= 51), 1);
    chk("tmo_code", err_code_at, 4);
    tick(); tick();
    chk("tmo_no_wr", wq.size(), 0);
    chk("tmo_busy", busy, 0);

    // Overrun in the middle of a commit.
    clr_mon();
    send_frame(vt[0]);
    send_byte(8'hA5);
    repeat (6) tick();
    chk("ovr_mid_nwr", wq.size(), 3);
    chk("ovr_mid_wr2", wq.size() == 3 ? wq[2] : 16'h0, 16'h1233);
    chk("ovr_mid_err", err_cnt, 1);
    chk("ovr_mid_code", err_code_at, 5);
    chk("ovr_mid_ok", ok_cnt, 1);
    chk("ovr_mid_code_after", err_code, 0);
    chk("ovr_mid_busy", busy, 0);

    // Overrun on the final write cycle: err and frame_ok together, code 5 kept.
    clr_mon();
    send_frame(vt[0]);
    tick(); tick();
    send_byte(8'h5A);
    repeat (4) tick();
    chk("ovr_last_nwr", wq.size(), 3);
    chk("ovr_last_both", both, 1);
    chk("ovr_last_code", err_code_at, 5);
    chk("ovr_last_ok", ok_cnt, 1);
    chk("ovr_last_code_after", err_code, 5);

    // Asynchronous reset while committing.
    clr_mon();
    send_frame(vt[0]);
    chk("rstc_wr_before", wr, 1);
    #2 rst = 1'b1;
    #1;
    chk("rstc_wr", wr, 0);
    chk("rstc_busy", busy, 0);
    chk("rstc_wr_addr", wr_addr, 0);
    chk("rstc_wr_data", wr_data, 0);
    chk("rstc_err_code", err_code, 0);
    chk("rstc_frame_ok", frame_ok, 0);
    @(negedge clk); rst = 1'b0;
    repeat (5) tick();
    chk("rstc_no_more_wr", wq.size(), 1);
    chk("rstc_no_ok", ok_cnt, 0);
    chk("rstc_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
